if_fetch_unit: RTL

- IF-stage fetch controller that drives instruction-memory requests and feeds decode.
- Owns the PC register, which holds the selected next PC: sequential PC+4 or redirect target.
- Hands the fetched instruction and its PC+4 to the IF/ID boundary with a valid bit.
- Supports decode stall (back-pressure), branch/jump redirect (flush), and variable-latency instruction memory.

---
 rtl/if_fetch_unit_if.sv | 12 +
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [ADDR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch controller: owns the PC, issues imem requests and feeds IF/ID with a
// one-entry skid buffer for decode stalls and a drain state for redirects with a request in flight.
module if_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    if_fetch_unit_if.master   imem,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [ADDR_W-1:0] pc
);
    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    state_e            state_q, state_d;
    logic              started_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [ADDR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0] id_pc4_q, id_pc4_d;
    logic              ack;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;

    // Acks without an active request are ignored.
    assign ack      = imem.imem_req & imem.imem_ack;
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign target   = redirect_pc & ~ADDR_W'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (redirect) begin
                    state_d = (imem.imem_req && !ack) ? StDrain : StFetch;
                end else if (ack && stall) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect || !stall) state_d = StFetch;
            end
            StDrain: begin
                if (ack) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // started_q keeps the request low until the first edge after reset release.
    always_comb begin
        imem.imem_req  = started_q && (state_q != StHold);
        imem.imem_addr = (state_q == StDrain) ? drain_addr_q : pc_q;
    end

    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc4_d     = id_pc4_q;
        if (redirect) begin
            pc_d         = target;
            id_valid_d   = 1'b0;
            skid_instr_d = '0;
            skid_pc4_d   = '0;
            if (state_q == StFetch) drain_addr_d = pc_q;
        end else begin
            case (state_q)
                StFetch: begin
                    if (ack) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            skid_instr_d = imem.imem_rdata;
                            skid_pc4_d   = pc_plus4;
                        end else begin
                            id_valid_d = 1'b1;
                            id_instr_d = imem.imem_rdata;
                            id_pc4_d   = pc_plus4;
                        end
                    end else if (!stall) begin
                        id_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        id_valid_d = 1'b1;
                        id_instr_d = skid_instr_q;
                        id_pc4_d   = skid_pc4_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc4_q     <= '0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc4_q     <= id_pc4_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc4_q;
    assign pc          = pc_q;
endmodule
